// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: upstream in_* side and downstream out_* side.
// The stage itself uses the slave view; whoever drives and observes the stage uses the master view.
interface pipe_skid_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer (main + skid) with fully registered in_ready and out_data,
// synchronous flush, per-item kill, and a saturating downstream stall counter.
module pipe_skid_stage #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 kill_in,
  pipe_skid_stage_if.slave     bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_acc;
  logic w_store;
  logic w_ofire;
  logic w_stall;

  assign w_acc   = bus.in_valid & r_in_ready;
  assign w_store = w_acc & ~kill_in;
  assign w_ofire = bus.out_valid & bus.out_ready;
  assign w_stall = bus.out_valid & ~bus.out_ready;

  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_data  = r_main;
  assign bus.in_ready  = r_in_ready;
  assign occupancy     = r_state;
  assign stall_cnt     = r_stall_cnt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      if (CLEAR_DATA) begin
        w_main_nxt = '0;
        w_skid_nxt = '0;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_store) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = bus.in_data;
          end
        end
        S_ONE: begin
          if (w_store && w_ofire) begin
            w_main_nxt = bus.in_data;
          end else if (w_store) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = bus.in_data;
          end else if (w_ofire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_ofire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the payload registers are reset too, so out_data reads zero during and after reset.
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      // Ready is a pure register of "skid empty next cycle": no in_valid/out_ready comb path.
      r_in_ready <= (w_state_nxt != S_FULL);
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
